// File: rtl/sccb_write_master.sv
// SCCB 3-phase write master: serialises slave ID, register address and register data on SIOC/SIOD.
// The 9th bit of each phase is released (don't-care); no ACK checking.
module sccb_write_master #(
    parameter int unsigned CLK_F    = 100_000_000,
    parameter int unsigned SCCB_F   = 100_000,
    parameter logic [7:0]  SLAVE_ID = 8'h42
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_start,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_sioc,
    output logic       o_siod,
    output logic       o_siod_oe
);

    localparam int unsigned QTR = CLK_F / (4 * SCCB_F);
    localparam int unsigned QW  = (QTR > 1) ? $clog2(QTR) : 1;

    if (QTR < 2) begin : g_qtr_check
        $error("sccb_write_master: CLK_F/(4*SCCB_F) must be >= 2");
    end

    typedef enum logic [1:0] {IDLE, START, BITS, STOP} state_t;

    state_t        state, nxt_state;
    logic [QW-1:0] qcnt;
    logic [1:0]    qtr, nxt_qtr;
    logic [3:0]    bitn, nxt_bitn;
    logic [1:0]    phase, nxt_phase;
    logic [7:0]    addr_q, data_q;
    logic [7:0]    cur_byte;
    logic          tick;
    logic          nxt_sioc, nxt_siod, nxt_oe;

    assign tick = (state != IDLE) && (qcnt == QW'(QTR - 1));

    // Next bus position: one quarter per tick, bits MSB first, 9 bits per phase.
    always_comb begin
        nxt_state = state;
        nxt_qtr   = qtr;
        nxt_bitn  = bitn;
        nxt_phase = phase;
        case (state)
            IDLE: begin
                if (i_start) begin
                    nxt_state = START;
                    nxt_qtr   = 2'd0;
                    nxt_bitn  = 4'd0;
                    nxt_phase = 2'd0;
                end
            end
            START: begin
                if (tick) begin
                    nxt_qtr = qtr + 2'd1;
                    if (qtr == 2'd3) nxt_state = BITS;
                end
            end
            BITS: begin
                if (tick) begin
                    nxt_qtr = qtr + 2'd1;
                    if (qtr == 2'd3) begin
                        if (bitn == 4'd8) begin
                            nxt_bitn = 4'd0;
                            if (phase == 2'd2) begin
                                nxt_phase = 2'd0;
                                nxt_state = STOP;
                            end else begin
                                nxt_phase = phase + 2'd1;
                            end
                        end else begin
                            nxt_bitn = bitn + 4'd1;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    nxt_qtr = qtr + 2'd1;
                    if (qtr == 2'd3) nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Bus levels for the position being entered; registered below.
    always_comb begin
        nxt_sioc = 1'b1;
        nxt_siod = 1'b1;
        nxt_oe   = 1'b1;
        case (nxt_phase)
            2'd0:    cur_byte = SLAVE_ID;
            2'd1:    cur_byte = addr_q;
            default: cur_byte = data_q;
        endcase
        case (nxt_state)
            START: begin
                nxt_sioc = (nxt_qtr != 2'd3);
                nxt_siod = (nxt_qtr == 2'd0);
            end
            BITS: begin
                nxt_sioc = (nxt_qtr == 2'd1) || (nxt_qtr == 2'd2);
                if (nxt_bitn == 4'd8) begin
                    nxt_oe = 1'b0;
                end else begin
                    nxt_siod = cur_byte[3'd7 - nxt_bitn[2:0]];
                end
            end
            STOP: begin
                nxt_sioc = (nxt_qtr != 2'd0);
                nxt_siod = (nxt_qtr >= 2'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state     <= IDLE;
            qcnt      <= '0;
            qtr       <= 2'd0;
            bitn      <= 4'd0;
            phase     <= 2'd0;
            addr_q    <= 8'd0;
            data_q    <= 8'd0;
            o_ready   <= 1'b1;
            o_sioc    <= 1'b1;
            o_siod    <= 1'b1;
            o_siod_oe <= 1'b1;
        end else begin
            state     <= nxt_state;
            qtr       <= nxt_qtr;
            bitn      <= nxt_bitn;
            phase     <= nxt_phase;
            qcnt      <= (state == IDLE || tick) ? '0 : qcnt + QW'(1);
            o_ready   <= (nxt_state == IDLE);
            o_sioc    <= nxt_sioc;
            o_siod    <= nxt_siod;
            o_siod_oe <= nxt_oe;
            if (state == IDLE && i_start) begin
                addr_q <= i_addr;
                data_q <= i_data;
            end
        end
    end

endmodule
